// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings, sequencer state type and opcode classification.
package alu_pkg;

  typedef logic [4:0] alu_op_t;

  localparam alu_op_t OP_NOP   = 5'b00000;
  localparam alu_op_t OP_MUL   = 5'b00010;
  localparam alu_op_t OP_DIV   = 5'b00011;
  localparam alu_op_t OP_SHIFT = 5'b00100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } seq_state_t;

  function automatic logic is_hilo_op(input alu_op_t op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Issues one op to the combinational ALU, holds inputs SETTLE_CYCLES, captures Z, returns it.
// Latency: SETTLE_CYCLES edges accept->rsp_valid; rsp holds until consumed, HI/LO commit on consume.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [4:0]          req_op,
  input  logic [DATA_W-1:0]   req_a,
  input  logic [DATA_W-1:0]   req_b,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [4:0]          alu_op,
  input  logic [2*DATA_W-1:0] alu_c,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_lo,
  output logic [DATA_W-1:0]   rsp_hi,
  output logic [4:0]          rsp_op,
  output logic                rsp_unsup,
  output logic [DATA_W-1:0]   hi_reg,
  output logic [DATA_W-1:0]   lo_reg,
  output logic                busy
);

  if (SETTLE_CYCLES < 1) begin : g_settle_chk
    $error("alu_op_sequencer: SETTLE_CYCLES must be >= 1");
  end

  localparam int CW = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE_CYCLES - 1);

  seq_state_t          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  alu_op_t             op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [2*DATA_W-1:0] z_q, z_d;
  logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic                unsup_q, unsup_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_NOP;
      a_q     <= '0;
      b_q     <= '0;
      z_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      unsup_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      z_q     <= z_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      unsup_q <= unsup_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    z_d       = z_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    unsup_d   = unsup_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    alu_op    = OP_NOP;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d    = req_op;
          a_d     = req_a;
          b_d     = req_b;
          unsup_d = !(is_hilo_op(req_op) || (req_op == OP_SHIFT));
          cnt_d   = CNT_INIT;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        alu_op = op_q;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          z_d     = alu_c;
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        // HI/LO commit only when the consumer takes the result, never at capture.
        if (rsp_ready) begin
          state_d = IDLE;
          if (is_hilo_op(op_q)) begin
            hi_d = z_q[2*DATA_W-1:DATA_W];
            lo_d = z_q[DATA_W-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign rsp_lo    = z_q[DATA_W-1:0];
  assign rsp_hi    = z_q[2*DATA_W-1:DATA_W];
  assign rsp_op    = op_q;
  assign rsp_unsup = unsup_q;
  assign hi_reg    = hi_q;
  assign lo_reg    = lo_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboarded bench for alu_op_sequencer with a behavioural ALU (SHIFT stubbable).
module tb_alu_op_sequencer;

  localparam int DW = 32;
  localparam int SC = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [4:0]    req_op = '0;
  logic [DW-1:0] req_a = '0, req_b = '0;
  logic [DW-1:0] alu_a, alu_b;
  logic [4:0]    alu_op;
  logic [2*DW-1:0] alu_c;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_lo, rsp_hi;
  logic [4:0]    rsp_op;
  logic          rsp_unsup;
  logic [DW-1:0] hi_reg, lo_reg;
  logic          busy;
  logic          stub_en = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [2*DW-1:0] alu_model(input logic [4:0] op, input logic [DW-1:0] a,
                                                input logic [DW-1:0] b, input logic stub);
    case (op)
      5'b00010: return {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
      5'b00011: return (b != 0) ? {a % b, a / b} : '0;
      5'b00100: return stub ? 64'h0000_0000_0000_0F00 : {{DW{1'b0}}, a << b[4:0]};
      default:  return '0;
    endcase
  endfunction

  assign alu_c = alu_model(alu_op, alu_a, alu_b, stub_en);

  alu_op_sequencer #(.DATA_W(DW), .SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_lo(rsp_lo), .rsp_hi(rsp_hi),
    .rsp_op(rsp_op), .rsp_unsup(rsp_unsup), .hi_reg(hi_reg), .lo_reg(lo_reg), .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [4:0]    op;
    logic [DW-1:0] lo;
    logic [DW-1:0] hi;
    logic          unsup;
  } exp_t;

  exp_t          sb_q[$];
  logic [DW-1:0] exp_hi = '0, exp_lo = '0;
  int            resp_cnt = 0;
  int            cyc = 0;
  int            acc_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Handshakes observed at negedge complete on the following rising edge.
  always @(negedge clk) begin
    if (rst_n && req_valid && req_ready) begin
      chk("acc_while_busy", {63'b0, busy}, 64'd0);
      acc_cyc.push_back(cyc);
    end
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_rsp", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("rsp_op", {59'b0, rsp_op}, {59'b0, e.op});
        chk("rsp_lo", {32'b0, rsp_lo}, {32'b0, e.lo});
        chk("rsp_hi", {32'b0, rsp_hi}, {32'b0, e.hi});
        chk("rsp_unsup", {63'b0, rsp_unsup}, {63'b0, e.unsup});
        if (e.op == 5'b00010 || e.op == 5'b00011) begin
          exp_hi = e.hi;
          exp_lo = e.lo;
        end
      end
      resp_cnt++;
    end
  end

  task automatic do_op(input logic [4:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] elo, input logic [DW-1:0] ehi, input logic eunsup,
                       input int hold);
    int lat, dcnt, w;
    sb_q.push_back('{op: op, lo: elo, hi: ehi, unsup: eunsup});
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!req_ready && w < 20);
    chk("req_ready_idle", {63'b0, req_ready}, 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("req_ready_drop", {63'b0, req_ready}, 64'd0);
    chk("busy_after_acc", {63'b0, busy}, 64'd1);
    lat = 0; dcnt = 0;
    while (!rsp_valid && lat < 20) begin
      if (alu_op == op) dcnt++;
      @(posedge clk); #1;
      lat++;
    end
    chk("rsp_latency", 64'(lat), 64'(SC));
    chk("alu_op_cycles", 64'(dcnt), 64'(SC));
    chk("alu_op_resp", {59'b0, alu_op}, 64'd0);
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", {63'b0, rsp_valid}, 64'd1);
      chk("hold_lo", {32'b0, rsp_lo}, {32'b0, elo});
      chk("hold_hi", {32'b0, rsp_hi}, {32'b0, ehi});
      chk("hold_lo_reg", {32'b0, lo_reg}, {32'b0, exp_lo});
      chk("hold_hi_reg", {32'b0, hi_reg}, {32'b0, exp_hi});
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", {63'b0, rsp_valid}, 64'd0);
    chk("lo_reg", {32'b0, lo_reg}, {32'b0, exp_lo});
    chk("hi_reg", {32'b0, hi_reg}, {32'b0, exp_hi});
  endtask

  initial begin : main
    int base, w, nv;
    logic [DW-1:0] sa[3], sb[3];
    sa[0] = 1; sa[1] = 3; sa[2] = 5;
    sb[0] = 2; sb[1] = 4; sb[2] = 6;

    #2;
    chk("rst_req_ready", {63'b0, req_ready}, 64'd1);
    chk("rst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_alu_op", {59'b0, alu_op}, 64'd0);
    chk("rst_hilo", {hi_reg, lo_reg}, 64'd0);
    chk("rst_rsp", {rsp_hi, rsp_lo}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(5'b00010, 7, 6, 42, 0, 1'b0, 0);
    chk("mul1_lo_reg", {32'b0, lo_reg}, 64'd42);

    do_op(5'b00010, 32'h0001_0000, 32'h0001_0000, 0, 1, 1'b0, 5);
    chk("mul2_hi_reg", {32'b0, hi_reg}, 64'd1);

    stub_en = 1'b1;
    do_op(5'b00100, 32'h1, 32'h8, 32'h0000_0F00, 0, 1'b0, 1);
    stub_en = 1'b0;
    chk("shift_keeps_hi", {32'b0, hi_reg}, 64'd1);
    chk("shift_keeps_lo", {32'b0, lo_reg}, 64'd0);

    do_op(5'b11111, 5, 9, 0, 0, 1'b1, 0);
    chk("unsup_keeps_hilo", {hi_reg, lo_reg}, {32'd1, 32'd0});

    // Back-to-back stream with req_valid held and the consumer always ready.
    base = resp_cnt;
    acc_cyc.delete();
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back('{op: 5'b00010, lo: sa[i] * sb[i], hi: 0, unsup: 1'b0});
      req_op = 5'b00010; req_a = sa[i]; req_b = sb[i]; req_valid = 1'b1;
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!req_ready && w < 20);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    w = 0;
    while (resp_cnt < base + 3 && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    rsp_ready = 1'b0;
    chk("stream_rsp_count", 64'(resp_cnt - base), 64'd3);
    chk("stream_acc_count", 64'(acc_cyc.size()), 64'd3);
    if (acc_cyc.size() == 3) begin
      chk("stream_gap1", 64'(acc_cyc[1] - acc_cyc[0]), 64'd4);
      chk("stream_gap2", 64'(acc_cyc[2] - acc_cyc[1]), 64'd4);
    end
    chk("stream_lo_reg", {32'b0, lo_reg}, 64'd30);

    // DIV aborted by an asynchronous reset while in DRIVE.
    req_op = 5'b00011; req_a = 100; req_b = 7; req_valid = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!req_ready && w < 20);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("div_in_drive", {59'b0, alu_op}, 64'd3);
    #2 rst_n = 1'b0;
    #1;
    sb_q.delete();
    exp_hi = '0; exp_lo = '0;
    chk("arst_busy", {63'b0, busy}, 64'd0);
    chk("arst_req_ready", {63'b0, req_ready}, 64'd1);
    chk("arst_alu_op", {59'b0, alu_op}, 64'd0);
    chk("arst_hilo", {hi_reg, lo_reg}, 64'd0);
    chk("arst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    nv = 0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) nv++;
    end
    rsp_ready = 1'b0;
    chk("arst_no_rsp", 64'(nv), 64'd0);
    chk("arst_hilo_after", {hi_reg, lo_reg}, 64'd0);
    @(posedge clk); #1;

    do_op(5'b00010, 2, 3, 6, 0, 1'b0, 0);
    chk("post_rst_lo", {32'b0, lo_reg}, 64'd6);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Initiator side of the ALU operand/result interface. It accepts one operation request through a valid/ready handshake.
- It drives operands and opcode to the combinational ALU and holds them stable for a fixed settle window.
- It then captures the 64-bit result into an internal Z register and returns it to the consumer through a valid/ready handshake.
- It owns the architectural HI/LO registers, which are updated only by MUL and DIV.

Parameters:
- DATA_W, 32: operand width; the result is 2*DATA_W.
- SETTLE_CYCLES, 2: number of cycles ALU inputs are held before capture. Must be >= 1; 0 is an elaboration error.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_op  in  5  opcode.
- req_a  in  DATA_W  operand A.
- req_b  in  DATA_W  operand B.
- alu_a  out  DATA_W  operand A to ALU.
- alu_b  out  DATA_W  operand B to ALU.
- alu_op  out  5  opcode to ALU.
- alu_c  in  2*DATA_W  ALU result.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result.
- rsp_lo  out  DATA_W  Z[DATA_W-1:0].
- rsp_hi  out  DATA_W  Z[2*DATA_W-1:DATA_W].
- rsp_op  out  5  opcode of the returned result.
- rsp_unsup  out  1  opcode was not MUL/DIV/SHIFT.
- hi_reg  out  DATA_W  architectural HI.
- lo_reg  out  DATA_W  architectural LO.
- busy  out  1  state != IDLE.

Behaviour:
- One clock domain (clk); reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, counter=0, op_reg=0, a_reg=0, b_reg=0, Z=0, hi_reg=0, lo_reg=0. All outputs are 0 except req_ready=1.
- FSM states: IDLE, DRIVE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready at edge T: latch req_op, req_a and req_b into op_reg, a_reg and b_reg; set counter=SETTLE_CYCLES-1; go to DRIVE.
- DRIVE:
  - alu_op=op_reg, alu_a=a_reg, alu_b=b_reg. All three are held constant for the whole state.
  - If counter!=0, decrement the counter.
  - If counter==0, capture Z<=alu_c and go to RESP.
  - The capture edge is T+SETTLE_CYCLES; rsp_valid rises right after it. Default latency is 2 edges from accept to rsp_valid.
- RESP:
  - rsp_valid=1. rsp_lo, rsp_hi, rsp_op and rsp_unsup come from registers and are stable until the handshake.
  - rsp_unsup is registered at accept.
  - On rsp_valid&&rsp_ready, go to IDLE. If op_reg is MUL or DIV, also write hi_reg<=Z[hi] and lo_reg<=Z[lo] at that same edge.
  - HI/LO commit on consumption, never on capture.
- alu_op outputs 0 in IDLE and RESP, which makes the ALU output 0. alu_a and alu_b keep their last values outside DRIVE.
- req_ready is 0 in DRIVE and RESP. Requests presented then are not accepted, and the requester must hold them.
- There is no same-cycle accept on the rsp handshake edge. Peak throughput is one op per SETTLE_CYCLES+2 cycles (RESP with rsp_ready already high, then one IDLE cycle).
- SHIFT returns the ALU result as-is: hi=0 and lo=shift result. HI/LO are unchanged.
- An unsupported opcode still runs the full sequence. The result is whatever alu_c gives (0 for the current ALU); rsp_unsup=1; HI/LO are unchanged.
- rsp_ready held high before RESP has no effect.
- rsp_valid must not drop before the handshake.
- Reset asserted mid-operation aborts immediately: all state returns to reset values, and an uncommitted MUL/DIV result is not written to HI/LO.
- Arithmetic: none inside the block; the only internal arithmetic is the counter decrement. The counter width is clog2(SETTLE_CYCLES)+1.

Decomposition:
- Shared package alu_pkg holds:
  - OP_MUL=5'b00010, OP_DIV=5'b00011, OP_SHIFT=5'b00100, OP_NOP=5'b00000.
  - An alu_op_t 5-bit type.
  - A seq_state_t enum {IDLE, DRIVE, RESP}.
  - Function is_hilo_op(op).
- The ALU package and this block both import alu_pkg.
- Single module; no sub-module is warranted. The HI/LO pair stays inline because its write condition is FSM-local.

Test Plan:
- Reset, then MUL a=7 b=6 with SETTLE_CYCLES=2 and real ALU:
  - req_ready drops the cycle after accept and alu_op=00010 for exactly 2 cycles.
  - rsp_valid rises 2 edges after accept with rsp_lo=42 and rsp_hi=0.
  - After the handshake, lo_reg=42 and hi_reg=0.
- MUL a=0x00010000 b=0x00010000 with rsp_ready held low for 5 cycles:
  - rsp_hi=1 and rsp_lo=0 stay stable for all 5 cycles.
  - hi_reg/lo_reg keep their old values until the handshake edge, then become 1/0.
- SHIFT after a MUL, with the ALU stubbed to return 0x0000000000000F00:
  - rsp_lo=0x00000F00 and rsp_hi=0.
  - hi_reg/lo_reg keep the prior MUL values.
- Unsupported op 5'b11111:
  - rsp_valid after 2 edges with rsp_lo=0, rsp_hi=0, rsp_unsup=1.
  - HI/LO unchanged.
- req_valid held high back-to-back with a stream of 3 MULs (1*2, 3*4, 5*6) and rsp_ready=1:
  - Exactly 3 responses in order: 2, 12, 30.
  - Each accept is 4 cycles apart.
  - No request is accepted while busy=1.
- DIV issued, then rst_n pulsed low in DRIVE (asynchronously, mid-cycle):
  - Outputs clear immediately and hi_reg=lo_reg=0.
  - No rsp_valid appears.
  - The next MUL 2*3 completes normally with lo=6.
